// File: rtl/bist_signature_check_if.sv
// Interface bundling the BIST controller/MISR inputs and the analyser result
// outputs of bist_signature_check. The fail_count signal exists only when
// BIST_FAIL_COUNT_EN is defined.
interface bist_signature_check_if #(
  parameter int unsigned SIG_W = 3
`ifdef BIST_FAIL_COUNT_EN
  , parameter int unsigned FAILCNT_W = 4
`endif
);
  logic             bist_init;
  logic             bist_running;
  logic             bist_finish;
  logic [SIG_W-1:0] sig_in;
  logic             pass_fail;
  logic             result_valid;
  logic [SIG_W-1:0] sig_captured;
  logic [SIG_W-1:0] sig_diff;
  logic             cnt_err;
  logic             proto_err;
  logic             busy;
`ifdef BIST_FAIL_COUNT_EN
  logic [FAILCNT_W-1:0] fail_count;
`endif

  // Controller / MISR side: drives the session controls, observes results.
  modport master (
    output bist_init, bist_running, bist_finish, sig_in,
    input  pass_fail, result_valid, sig_captured, sig_diff,
    input  cnt_err, proto_err, busy
`ifdef BIST_FAIL_COUNT_EN
    , input fail_count
`endif
  );

  // Analyser side.
  modport slave (
    input  bist_init, bist_running, bist_finish, sig_in,
    output pass_fail, result_valid, sig_captured, sig_diff,
    output cnt_err, proto_err, busy
`ifdef BIST_FAIL_COUNT_EN
    , output fail_count
`endif
  );
endinterface

// File: rtl/bist_signature_check.sv
// bist_signature_check: BIST signature analyser and comparator.
// Counts bist_running cycles per session, captures the MISR signature on
// bist_finish, compares it with GOLDEN_SIG one cycle later and holds a sticky
// registered result until the next bist_init. Flags cycle-count and protocol
// errors. Optional feature macro: BIST_FAIL_COUNT_EN (adds fail_count).
module bist_signature_check #(
  parameter int unsigned      SIG_W      = 3,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = 3'b101,
  parameter int unsigned      CNT_W      = 8,
  parameter logic [CNT_W-1:0] EXP_CYCLES = 8'd7
`ifdef BIST_FAIL_COUNT_EN
  , parameter int unsigned    FAILCNT_W  = 4
`endif
) (
  input logic                    CLK,
  input logic                    RST,
  bist_signature_check_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_RUN,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic             valid_q, valid_d;
  logic [SIG_W-1:0] sig_cap_q, sig_cap_d;
  logic [SIG_W-1:0] sig_diff_q, sig_diff_d;
  logic             cnt_err_q, cnt_err_d;
  logic             proto_q, proto_d;
  logic             busy_q, busy_d;

  logic [SIG_W-1:0] diff_w;
  logic             cnt_bad_w;

  assign diff_w    = sig_cap_q ^ GOLDEN_SIG;
  assign cnt_bad_w = (cnt_q != EXP_CYCLES);

  // State and result registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pass_q     <= 1'b0;
      valid_q    <= 1'b0;
      sig_cap_q  <= '0;
      sig_diff_q <= '0;
      cnt_err_q  <= 1'b0;
      proto_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pass_q     <= pass_d;
      valid_q    <= valid_d;
      sig_cap_q  <= sig_cap_d;
      sig_diff_q <= sig_diff_d;
      cnt_err_q  <= cnt_err_d;
      proto_q    <= proto_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state selection; bist_init overrides everything.
  always_comb begin
    state_d = state_q;
    if (bus.bist_init) begin
      state_d = S_ARMED;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_ARMED: begin
          if (bus.bist_finish)       state_d = S_DONE;
          else if (bus.bist_running) state_d = S_RUN;
        end
        S_RUN:   if (bus.bist_finish) state_d = S_CHECK;
        S_CHECK: state_d = S_DONE;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Next values of the counter and registered outputs.
  always_comb begin
    cnt_d      = cnt_q;
    pass_d     = pass_q;
    valid_d    = valid_q;
    sig_cap_d  = sig_cap_q;
    sig_diff_d = sig_diff_q;
    cnt_err_d  = cnt_err_q;
    proto_d    = proto_q;
    busy_d     = (state_d == S_ARMED) || (state_d == S_RUN) || (state_d == S_CHECK);
    if (bus.bist_init) begin
      // sig_captured is deliberately kept across a restart.
      cnt_d      = '0;
      pass_d     = 1'b0;
      valid_d    = 1'b0;
      sig_diff_d = '0;
      cnt_err_d  = 1'b0;
      proto_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.bist_finish || bus.bist_running) proto_d = 1'b1;
        end
        S_ARMED: begin
          if (bus.bist_finish) begin
            proto_d = 1'b1;
            pass_d  = 1'b0;
            valid_d = 1'b1;
          end else if (bus.bist_running) begin
            cnt_d = CNT_W'(1);
          end
        end
        S_RUN: begin
          if (bus.bist_running && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
          if (bus.bist_finish) sig_cap_d = bus.sig_in;
        end
        S_CHECK: begin
          sig_diff_d = diff_w;
          cnt_err_d  = cnt_bad_w;
          pass_d     = (diff_w == '0) && !cnt_bad_w;
          valid_d    = 1'b1;
        end
        S_DONE: begin
          if (bus.bist_finish || bus.bist_running) proto_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.pass_fail    = pass_q;
  assign bus.result_valid = valid_q;
  assign bus.sig_captured = sig_cap_q;
  assign bus.sig_diff     = sig_diff_q;
  assign bus.cnt_err      = cnt_err_q;
  assign bus.proto_err    = proto_q;
  assign bus.busy         = busy_q;

`ifdef BIST_FAIL_COUNT_EN
  logic [FAILCNT_W-1:0] fail_cnt_q;
  logic                 fail_inc;

  assign fail_inc = !bus.bist_init &&
                    (((state_q == S_CHECK) && !pass_d) ||
                     ((state_q == S_ARMED) && bus.bist_finish));

  // Failed-session counter, saturating; survives bist_init.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fail_cnt_q <= '0;
    end else if (fail_inc && (fail_cnt_q != '1)) begin
      fail_cnt_q <= fail_cnt_q + FAILCNT_W'(1);
    end
  end

  assign bus.fail_count = fail_cnt_q;
`endif

endmodule
